// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a blocking miss FSM.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
    parameter int LINES = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p1_req_i,
    input  logic          p1_MemRead_i,
    input  logic          p1_MemWrite_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_data_i,
    output logic [31:0]   p1_data_o,
    output logic          p1_stall_o,
    output logic          mem_enable_o,
    output logic          mem_write_o,
    output logic [31:0]   mem_addr_o,
    output logic [255:0]  mem_data_o,
    input  logic [255:0]  mem_data_i,
    input  logic          mem_ack_i,
    output logic [31:0]   hit_count_o,
    output logic [31:0]   miss_count_o
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 27 - INDEX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MISS      = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        REFILL    = 3'd4
    } state_t;

    state_t               state_r, next_state_s;
    logic [LINES-1:0]     valid_r, dirty_r;
    logic [TAG_W-1:0]     tag_r  [LINES];
    logic [255:0]         data_r [LINES];
    logic [INDEX_W-1:0]   miss_index_r;
    logic [TAG_W-1:0]     miss_tag_r;
    logic                 mem_enable_r, mem_write_r;
    logic [31:0]          mem_addr_r;
    logic [255:0]         mem_data_r;

    logic [INDEX_W-1:0]   req_index_s;
    logic [TAG_W-1:0]     req_tag_s;
    logic [2:0]           word_sel_s;
    logic                 idle_s, hit_s, write_hit_s, read_hit_s, fill_s, miss_start_s;
    logic                 unused_s;

    function automatic logic [31:0] get_word(input logic [255:0] line, input logic [2:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

    assign req_index_s  = p1_addr_i[5 +: INDEX_W];
    assign req_tag_s    = p1_addr_i[31 -: TAG_W];
    assign word_sel_s   = p1_addr_i[4:2];
    assign unused_s     = ^p1_addr_i[1:0];
    assign idle_s       = (state_r == IDLE);
    assign hit_s        = p1_req_i & valid_r[req_index_s] & (tag_r[req_index_s] == req_tag_s);
    // Hits are only served from IDLE; the held request is replayed there after a refill.
    assign write_hit_s  = idle_s & hit_s & p1_MemWrite_i;
    assign read_hit_s   = idle_s & hit_s & p1_MemRead_i & ~p1_MemWrite_i;
    assign fill_s       = (state_r == ALLOCATE) & mem_ack_i;
    assign miss_start_s = idle_s & (next_state_s == MISS);

    // Next-state logic of the miss FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (p1_req_i && !hit_s) next_state_s = MISS;
                else                    next_state_s = IDLE;
            end
            MISS: begin
                if (valid_r[miss_index_r] && dirty_r[miss_index_r]) next_state_s = WRITEBACK;
                else                                                next_state_s = ALLOCATE;
            end
            WRITEBACK: begin
                if (mem_ack_i) next_state_s = ALLOCATE;
                else           next_state_s = WRITEBACK;
            end
            ALLOCATE: begin
                if (mem_ack_i) next_state_s = REFILL;
                else           next_state_s = ALLOCATE;
            end
            REFILL:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Latch the missing line's index and tag so a dropped request cannot disturb the transfer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            miss_index_r <= {INDEX_W{1'b0}};
            miss_tag_r   <= {TAG_W{1'b0}};
        end else if (miss_start_s) begin
            miss_index_r <= req_index_s;
            miss_tag_r   <= req_tag_s;
        end
    end

    // Registered memory request: loaded on entry to a transfer state, held until ack, else zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_data_r   <= 256'd0;
        end else begin
            case (next_state_s)
                WRITEBACK: begin
                    if (state_r != WRITEBACK) begin
                        mem_enable_r <= 1'b1;
                        mem_write_r  <= 1'b1;
                        mem_addr_r   <= {tag_r[miss_index_r], miss_index_r, 5'b00000};
                        mem_data_r   <= data_r[miss_index_r];
                    end
                end
                ALLOCATE: begin
                    if (state_r != ALLOCATE) begin
                        mem_enable_r <= 1'b1;
                        mem_write_r  <= 1'b0;
                        mem_addr_r   <= {miss_tag_r, miss_index_r, 5'b00000};
                        mem_data_r   <= 256'd0;
                    end
                end
                default: begin
                    mem_enable_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= 32'd0;
                    mem_data_r   <= 256'd0;
                end
            endcase
        end
    end

    // Valid and dirty bits; the only per-line state cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else if (fill_s) begin
            valid_r[miss_index_r] <= 1'b1;
            dirty_r[miss_index_r] <= 1'b0;
        end else if (write_hit_s) begin
            dirty_r[req_index_s] <= 1'b1;
        end
    end

    // Tag and data arrays: refill on ack, word merge on a store hit.
    always_ff @(posedge clk_i) begin
        if (rst_i && fill_s) begin
            data_r[miss_index_r] <= mem_data_i;
            tag_r[miss_index_r]  <= miss_tag_r;
        end else if (rst_i && write_hit_s) begin
            data_r[req_index_s][{word_sel_s, 5'b00000} +: 32] <= p1_data_i;
        end
    end

    // CPU-side load data and pipeline stall.
    always_comb begin
        p1_data_o  = 32'd0;
        p1_stall_o = 1'b0;
        if (read_hit_s) p1_data_o = get_word(data_r[req_index_s], word_sel_s);
        else            p1_data_o = 32'd0;
        if (!idle_s || (p1_req_i && !hit_s)) p1_stall_o = 1'b1;
        else                                 p1_stall_o = 1'b0;
    end

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_r, miss_count_r;
    logic        post_refill_r;

    // The first IDLE cycle after REFILL replays the missed access and is not a countable hit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_count_r   <= 32'd0;
            miss_count_r  <= 32'd0;
            post_refill_r <= 1'b0;
        end else begin
            post_refill_r <= (state_r == REFILL);
            if (miss_start_s) miss_count_r <= miss_count_r + 32'd1;
            if (idle_s && hit_s && !post_refill_r) hit_count_r <= hit_count_r + 32'd1;
        end
    end

    assign hit_count_o  = hit_count_r;
    assign miss_count_o = miss_count_r;
`else
    assign hit_count_o  = 32'd0;
    assign miss_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed, table-driven bench for dcache_controller with a latency-programmable memory responder.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0]  addr = 32'd0, wdata = 32'd0;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_en, mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = 256'd0;
    logic         mem_ack = 1'b0;
    logic [31:0]  hit_cnt, miss_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic        req;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_stall;
        string       name;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    dcache_controller #(.LINES(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .p1_req_i(req), .p1_MemRead_i(rd), .p1_MemWrite_i(wr),
        .p1_addr_i(addr), .p1_data_i(wdata), .p1_data_o(rdata), .p1_stall_o(stall),
        .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
    );

    function automatic logic [255:0] blk(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'h1234_5678 + ((a - 32'h40) << 4) + 32'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic lr, input logic lw, input logic [31:0] a, input logic [31:0] d);
        req = r; rd = lr; wr = lw; addr = a; wdata = d;
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.req, v.rd, v.wr, v.addr, v.wdata);
        #1;
        chk({v.name, "_data"}, 256'(rdata), 256'(v.exp_data));
        chk({v.name, "_stall"}, 256'(stall), 256'(v.exp_stall));
        tick();
    endtask

    // Wait for a memory request, check it, keep it pending for lat cycles, then pulse ack.
    task automatic serve(input int lat, input logic [31:0] exp_addr, input logic exp_wr,
                         output logic [255:0] wb);
        int n = 0;
        wb = 256'd0;
        while (!mem_en && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_seen", 256'(mem_en), 256'(1'b1));
        chk("mem_addr", 256'(mem_addr), 256'(exp_addr));
        chk("mem_write", 256'(mem_wr), 256'(exp_wr));
        wb = mem_wdata;
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("mem_hold", 256'({mem_en, mem_addr}), 256'({1'b1, exp_addr}));
            chk("stall_xfer", 256'(stall), 256'(1'b1));
        end
        mem_rdata = blk(exp_addr);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [255:0] wb;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h44,  32'hDEAD_BEEF, 32'h0,         1'b0, "st44"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h44,  32'h0,         32'hDEAD_BEEF, 1'b0, "ld44"};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h40,  32'h0,         32'h1234_5678, 1'b0, "ld40"};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h5C,  32'h0,         32'h1234_567F, 1'b0, "ld5c"};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h44,  32'h0,         32'h0,         1'b0, "noreq44"};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h48,  32'h0BAD_F00D, 32'h0,         1'b0, "rw48"};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h48,  32'h0,         32'h0BAD_F00D, 1'b0, "ld48"};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h440, 32'h0,         32'h0,         1'b0, "noreq440"};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h800, 32'h0,         32'hCAFE_0001, 1'b0, "ld800"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h804, 32'h0,         32'h1234_D279, 1'b0, "ld804"};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h81C, 32'h0,         32'h1234_D27F, 1'b0, "ld81c"};

        tick();
        do_reset();
        chk("rst_stall", 256'(stall), 256'(1'b0));
        chk("rst_mem", 256'({mem_en, mem_wr, mem_addr}), 256'(0));
        chk("rst_data", 256'(rdata), 256'(0));
        chk("rst_cnt", 256'({hit_cnt, miss_cnt}), 256'(0));

        // Cold read miss, ack 3 cycles after enable rises.
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        #1;
        chk("cold_t0_stall", 256'(stall), 256'(1'b1));
        chk("cold_t0_data", 256'(rdata), 256'(0));
        tick();
        chk("cold_t1_stall", 256'(stall), 256'(1'b1));
        chk("cold_t1_en", 256'(mem_en), 256'(1'b0));
        serve(3, 32'h40, 1'b0, wb);
        chk("cold_refill_stall", 256'(stall), 256'(1'b1));
        tick();
        chk("cold_idle_stall", 256'(stall), 256'(1'b0));
        chk("cold_idle_data", 256'(rdata), 256'(32'h1234_5678));
        chk("cold_idle_en", 256'(mem_en), 256'(1'b0));
        tick();

        for (int i = 0; i <= 7; i++) apply_vec(vecs[i]);

        // Dirty eviction of 0x40 by 0x440 (same index).
        drive(1'b1, 1'b1, 1'b0, 32'h440, 32'd0);
        #1;
        chk("evict_stall", 256'(stall), 256'(1'b1));
        serve(1, 32'h40, 1'b1, wb);
        chk("wb_word0", 256'(wb[31:0]), 256'(32'h1234_5678));
        chk("wb_word1", 256'(wb[63:32]), 256'(32'hDEAD_BEEF));
        chk("wb_word2", 256'(wb[95:64]), 256'(32'h0BAD_F00D));
        serve(2, 32'h440, 1'b0, wb);
        tick();
        chk("evict_idle_stall", 256'(stall), 256'(1'b0));
        chk("evict_idle_data", 256'(rdata), 256'(32'h1234_9678));
        tick();

        // Store miss: refill first, then merge.
        drive(1'b1, 1'b0, 1'b1, 32'h800, 32'hCAFE_0001);
        #1;
        chk("stmiss_stall", 256'(stall), 256'(1'b1));
        serve(2, 32'h800, 1'b0, wb);
        chk("stmiss_refill_stall", 256'(stall), 256'(1'b1));
        tick();
        chk("stmiss_idle_stall", 256'(stall), 256'(1'b0));
        tick();
        for (int i = 8; i <= 10; i++) apply_vec(vecs[i]);

        // Reset during ALLOCATE of 0x60.
        drive(1'b1, 1'b1, 1'b0, 32'h60, 32'd0);
        tick();
        tick();
        chk("alloc_en", 256'({mem_en, mem_wr, mem_addr}), 256'({1'b1, 1'b0, 32'h60}));
        do_reset();
        chk("midrst_en", 256'({mem_en, mem_addr}), 256'(0));
        chk("midrst_stall", 256'(stall), 256'(1'b0));
        drive(1'b1, 1'b1, 1'b0, 32'h440, 32'd0);
        #1;
        chk("midrst_remiss", 256'(stall), 256'(1'b1));
        serve(1, 32'h440, 1'b0, wb);
        tick();
        chk("midrst_idle_data", 256'(rdata), 256'(32'h1234_9678));
        tick();

        // Statistics: one miss followed by four hits.
        do_reset();
        chk("stat_rst", 256'({hit_cnt, miss_cnt}), 256'(0));
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        #1;
        chk("stat_miss_stall", 256'(stall), 256'(1'b1));
        serve(0, 32'h40, 1'b0, wb);
        tick();
        chk("stat_refill_data", 256'(rdata), 256'(32'h1234_5678));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stat_hit_stall", 256'(stall), 256'(1'b0));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("stat_miss_cnt", 256'(miss_cnt), 256'(STATS ? 32'd1 : 32'd0));
        chk("stat_hit_cnt", 256'(hit_cnt), 256'(STATS ? 32'd4 : 32'd0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
